// File: rtl/draw_pkg.sv
// Shared definitions for the sprite draw scheduler.
// Holds the scheduler state encoding and the default screen geometry and
// background colour used as parameter defaults by the other files.
package draw_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_IDLE  = 3'd1,
        ST_SNAP  = 3'd2,
        ST_ERASE = 3'd3,
        ST_DRAW  = 3'd4,
        ST_NEXT  = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    localparam int         DEF_SCR_W = 160;
    localparam int         DEF_SCR_H = 120;
    localparam logic [2:0] DEF_BG    = 3'b000;

endpackage

// File: rtl/sprite_scan.sv
// Rectangle scan counter shared by the full-screen clear and the sprite scans.
// A load captures the rectangle size and restarts at offset (0,0); each
// advance steps the offset in row-major order (ox fastest).
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   load_i               restart the scan with size w_i x h_i
//   adv_i                step to the next offset
//   w_i, h_i             rectangle size captured on load_i
//   org_x_i, org_y_i     rectangle origin (held by the caller for the scan)
//   x_o, y_o             current screen coordinate (origin + offset)
//   last_o               current offset is the final one of the rectangle
//   clip_o               current coordinate lies outside the screen
module sprite_scan
    import draw_pkg::*;
#(
    parameter int XW    = 8,
    parameter int YW    = 7,
    parameter int SCR_W = DEF_SCR_W,
    parameter int SCR_H = DEF_SCR_H
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic          adv_i,
    input  logic [XW-1:0] w_i,
    input  logic [YW-1:0] h_i,
    input  logic [XW-1:0] org_x_i,
    input  logic [YW-1:0] org_y_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o,
    output logic          clip_o
);

    localparam logic [XW:0] LIM_X = (XW+1)'(SCR_W);
    localparam logic [YW:0] LIM_Y = (YW+1)'(SCR_H);

    logic [XW-1:0] ox_q, ox_d, w_q;
    logic [YW-1:0] oy_q, oy_d, h_q;
    logic [XW:0]   sum_x;
    logic [YW:0]   sum_y;
    logic          last_x, last_y;

    assign last_x = (ox_q == w_q - XW'(1));
    assign last_y = (oy_q == h_q - YW'(1));
    assign last_o = last_x & last_y;

    // One guard bit so an origin near the right/bottom edge cannot wrap
    // back onto the screen.
    assign sum_x  = {1'b0, org_x_i} + {1'b0, ox_q};
    assign sum_y  = {1'b0, org_y_i} + {1'b0, oy_q};
    assign clip_o = (sum_x >= LIM_X) || (sum_y >= LIM_Y);
    assign x_o    = sum_x[XW-1:0];
    assign y_o    = sum_y[YW-1:0];

    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        ox_d = ox_q;
        oy_d = oy_q;
        if (load_i) begin
            ox_d = '0;
            oy_d = '0;
        end else if (adv_i) begin
            if (last_x) begin
                ox_d = '0;
                oy_d = last_y ? '0 : oy_q + YW'(1);
            end else begin
                ox_d = ox_q + XW'(1);
            end
        end
    end

    // The reset size is the full screen so the clear that follows reset
    // needs no explicit load.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ox_q <= '0;
            oy_q <= '0;
            w_q  <= XW'(SCR_W);
            h_q  <= YW'(SCR_H);
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            ox_q <= ox_d;
            oy_q <= oy_d;
            if (load_i) begin
                w_q <= w_i;
                h_q <= h_i;
            end
        end
    end

endmodule

// File: rtl/draw_scheduler.sv
// Sprite draw scheduler: after reset it paints the whole screen with the
// background colour, then on each frame_start it snapshots the sprite table
// and, slot by slot, erases the footprint drawn last frame and draws the new
// one. Pixels leave on a valid/ready stream; off-screen pixels are skipped.
// Ports:
//   clk, resetn                    clock, asynchronous active-low reset
//   frame_start                    request one frame (honoured only in IDLE)
//   obj_en/obj_big                 per-slot enable and big-sprite select
//   obj_x/obj_y/obj_col            packed per-slot origin and colour
//   pix_x/pix_y/pix_col/pix_valid  pixel stream, held while stalled
//   pix_ready                      sink accepts the offered pixel
//   busy                           not idle
//   frame_done                     one-cycle pulse at the end of a frame
//   overrun                        one-cycle pulse when frame_start is dropped
module draw_scheduler
    import draw_pkg::*;
#(
    parameter int            N_OBJ = 8,
    parameter int            SPR_W = 5,
    parameter int            SPR_H = 5,
    parameter int            SCR_W = DEF_SCR_W,
    parameter int            SCR_H = DEF_SCR_H,
    parameter int            XW    = 8,
    parameter int            YW    = 7,
    parameter int            CW    = 3,
    parameter logic [CW-1:0] BG    = CW'(DEF_BG)
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                frame_start,
    input  logic [N_OBJ-1:0]    obj_en,
    input  logic [N_OBJ-1:0]    obj_big,
    input  logic [N_OBJ*XW-1:0] obj_x,
    input  logic [N_OBJ*YW-1:0] obj_y,
    input  logic [N_OBJ*CW-1:0] obj_col,
    output logic [XW-1:0]       pix_x,
    output logic [YW-1:0]       pix_y,
    output logic [CW-1:0]       pix_col,
    output logic                pix_valid,
    input  logic                pix_ready,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);

    localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] i_q, i_d;
    logic          run_q;

    // Shadow copy of the sprite table, captured once per frame.
    logic [N_OBJ-1:0]    sh_en_q, sh_big_q;
    logic [N_OBJ*XW-1:0] sh_x_q;
    logic [N_OBJ*YW-1:0] sh_y_q;
    logic [N_OBJ*CW-1:0] sh_col_q;

    // Footprint each slot left on screen, used by the next erase.
    logic [N_OBJ-1:0]    prev_big_q, prev_drawn_q;
    logic [N_OBJ*XW-1:0] prev_x_q;
    logic [N_OBJ*YW-1:0] prev_y_q;

    logic          snap, commit;
    logic          scan_load, scan_adv, scan_last, scan_clip, scan_active;
    logic [XW-1:0] scan_w, scan_org_x, scan_x;
    logic [YW-1:0] scan_h, scan_org_y, scan_y;
    logic [CW-1:0] scan_col;

    sprite_scan #(
        .XW    (XW),
        .YW    (YW),
        .SCR_W (SCR_W),
        .SCR_H (SCR_H)
    ) u_scan (
        .clk_i   (clk),
        .rst_ni  (resetn),
        .load_i  (scan_load),
        .adv_i   (scan_adv),
        .w_i     (scan_w),
        .h_i     (scan_h),
        .org_x_i (scan_org_x),
        .org_y_i (scan_org_y),
        .x_o     (scan_x),
        .y_o     (scan_y),
        .last_o  (scan_last),
        .clip_o  (scan_clip)
    );

    // Origin, colour and "has pixels" for the scan running in this state.
    // run_q keeps the clear silent until the first edge after reset.
    always_comb begin
        scan_org_x  = '0;
        scan_org_y  = '0;
        scan_col    = BG;
        scan_active = 1'b0;
        case (state_q)
            ST_CLEAR: scan_active = run_q;
            ST_ERASE: begin
                scan_org_x  = prev_x_q[int'(i_q)*XW +: XW];
                scan_org_y  = prev_y_q[int'(i_q)*YW +: YW];
                scan_active = prev_drawn_q[i_q];
            end
            ST_DRAW: begin
                scan_org_x  = sh_x_q[int'(i_q)*XW +: XW];
                scan_org_y  = sh_y_q[int'(i_q)*YW +: YW];
                scan_col    = sh_col_q[int'(i_q)*CW +: CW];
                scan_active = sh_en_q[i_q];
            end
            default: ;
        endcase
    end

    // Clipped pixels advance without waiting for the sink.
    assign pix_valid = scan_active & ~scan_clip;
    assign scan_adv  = scan_active & (scan_clip | pix_ready);

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        scan_load  = 1'b0;
        snap       = 1'b0;
        commit     = 1'b0;
        case (state_q)
            ST_CLEAR: if (scan_adv && scan_last) state_d = ST_IDLE;
            ST_IDLE:  if (frame_start) state_d = ST_SNAP;
            ST_SNAP: begin
                snap      = 1'b1;
                i_d       = '0;
                scan_load = 1'b1;
                state_d   = ST_ERASE;
            end
            ST_ERASE: begin
                if (!scan_active || (scan_adv && scan_last)) begin
                    scan_load = 1'b1;
                    state_d   = ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (!scan_active || (scan_adv && scan_last)) begin
                    commit  = 1'b1;
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (i_q == IW'(N_OBJ - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    i_d       = i_q + IW'(1);
                    scan_load = 1'b1;
                    state_d   = ST_ERASE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_CLEAR;
        endcase
    end

    // Size for the scan being entered, so it is in place on its first cycle.
    always_comb begin
        scan_w = XW'(1);
        scan_h = YW'(1);
        case (state_d)
            ST_ERASE: if (prev_big_q[i_d]) begin
                scan_w = XW'(SPR_W);
                scan_h = YW'(SPR_H);
            end
            ST_DRAW: if (sh_big_q[i_d]) begin
                scan_w = XW'(SPR_W);
                scan_h = YW'(SPR_H);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_CLEAR;
            i_q          <= '0;
            run_q        <= 1'b0;
            // NOTE: the shadow and footprint tables are reset because the
            // first erase after reset must see no slot as drawn.
            sh_en_q      <= '0;
            sh_big_q     <= '0;
            sh_x_q       <= '0;
            sh_y_q       <= '0;
            sh_col_q     <= '0;
            prev_big_q   <= '0;
            prev_drawn_q <= '0;
            prev_x_q     <= '0;
            prev_y_q     <= '0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            run_q   <= 1'b1;
            if (snap) begin
                sh_en_q  <= obj_en;
                sh_big_q <= obj_big;
                sh_x_q   <= obj_x;
                sh_y_q   <= obj_y;
                sh_col_q <= obj_col;
            end
            if (commit) begin
                prev_x_q[int'(i_q)*XW +: XW] <= sh_x_q[int'(i_q)*XW +: XW];
                prev_y_q[int'(i_q)*YW +: YW] <= sh_y_q[int'(i_q)*YW +: YW];
                prev_big_q[i_q]              <= sh_big_q[i_q];
                prev_drawn_q[i_q]            <= sh_en_q[i_q];
            end
        end
    end

    // Pixel fields read as zero whenever nothing is offered.
    assign pix_x      = pix_valid ? scan_x   : '0;
    assign pix_y      = pix_valid ? scan_y   : '0;
    assign pix_col    = pix_valid ? scan_col : '0;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    // Any request outside IDLE, DONE included, is dropped here; held low in reset.
    assign overrun    = resetn & frame_start & (state_q != ST_IDLE);

endmodule

// File: tb/tb_draw_scheduler.sv
// Self-checking bench for draw_scheduler: expected pixels are pushed to a
// scoreboard queue from a reference model of the sprite footprints and
// popped as the DUT hands pixels over.
module tb_draw_scheduler;

    localparam int N_OBJ = 8;
    localparam int XW    = 8;
    localparam int YW    = 7;
    localparam int CW    = 3;
    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam logic [CW-1:0] BGC = 3'b000;

    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] c;
    } pix_t;

    logic                clk;
    logic                resetn;
    logic                frame_start;
    logic [N_OBJ-1:0]    obj_en, obj_big;
    logic [N_OBJ*XW-1:0] obj_x;
    logic [N_OBJ*YW-1:0] obj_y;
    logic [N_OBJ*CW-1:0] obj_col;
    logic [XW-1:0]       pix_x;
    logic [YW-1:0]       pix_y;
    logic [CW-1:0]       pix_col;
    logic                pix_valid, pix_ready, busy, frame_done, overrun;

    draw_scheduler #(
        .N_OBJ(N_OBJ), .SPR_W(5), .SPR_H(5), .SCR_W(SCR_W), .SCR_H(SCR_H),
        .XW(XW), .YW(YW), .CW(CW), .BG(BGC)
    ) dut (
        .clk(clk), .resetn(resetn), .frame_start(frame_start),
        .obj_en(obj_en), .obj_big(obj_big), .obj_x(obj_x), .obj_y(obj_y),
        .obj_col(obj_col), .pix_x(pix_x), .pix_y(pix_y), .pix_col(pix_col),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy),
        .frame_done(frame_done), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pix_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   px_count = 0;
    int   fd_count = 0;
    bit   rand_ready = 1'b0;

    // Reference model of what each slot left on screen.
    int m_x[N_OBJ];
    int m_y[N_OBJ];
    bit m_big[N_OBJ];
    bit m_drawn[N_OBJ];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
        pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    // Monitor: sampled on the falling edge, away from the handshake edge.
    bit   stall = 1'b0;
    pix_t st_pix;
    always @(negedge clk) begin
        if (!resetn) begin
            stall = 1'b0;
        end else begin
            if (stall)
                check("stall_hold", {pix_valid, pix_x, pix_y, pix_col}, {1'b1, st_pix});
            if (frame_done) fd_count++;
            if (pix_valid && pix_ready) begin
                px_count++;
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", {pix_x, pix_y, pix_col}, 32'hffff_ffff);
                end else begin
                    pix_t e;
                    e = exp_q.pop_front();
                    check("pixel", {pix_x, pix_y, pix_col}, e);
                end
            end
            stall  = pix_valid & ~pix_ready;
            st_pix = {pix_x, pix_y, pix_col};
        end
    end

    task automatic push_fp(input int x, input int y, input bit big, input logic [CW-1:0] c);
        int   w;
        pix_t p;
        w = big ? 5 : 1;
        for (int oy = 0; oy < w; oy++)
            for (int ox = 0; ox < w; ox++)
                if (x + ox < SCR_W && y + oy < SCR_H) begin
                    p.x = XW'(x + ox);
                    p.y = YW'(y + oy);
                    p.c = c;
                    exp_q.push_back(p);
                end
    endtask

    task automatic push_frame();
        for (int s = 0; s < N_OBJ; s++) begin
            if (m_drawn[s]) push_fp(m_x[s], m_y[s], m_big[s], BGC);
            if (obj_en[s])
                push_fp(int'(obj_x[s*XW +: XW]), int'(obj_y[s*YW +: YW]), obj_big[s],
                        obj_col[s*CW +: CW]);
            m_x[s]     = int'(obj_x[s*XW +: XW]);
            m_y[s]     = int'(obj_y[s*YW +: YW]);
            m_big[s]   = obj_big[s];
            m_drawn[s] = obj_en[s];
        end
    endtask

    task automatic set_slot(input int s, input bit en, input bit big, input int x, input int y,
                            input int c);
        obj_en[s]            = en;
        obj_big[s]           = big;
        obj_x[s*XW +: XW]    = XW'(x);
        obj_y[s*YW +: YW]    = YW'(y);
        obj_col[s*CW +: CW]  = CW'(c);
    endtask

    // Release reset and watch the full-screen clear, with a dropped request.
    task automatic clear_phase();
        bit done, saw_busy;
        pix_t p;
        exp_q.delete();
        for (int y = 0; y < SCR_H; y++)
            for (int x = 0; x < SCR_W; x++) begin
                p.x = XW'(x);
                p.y = YW'(y);
                p.c = BGC;
                exp_q.push_back(p);
            end
        px_count = 0;
        resetn = 1'b1;
        step();
        check("clear_first", {pix_valid, pix_x, pix_y}, {1'b1, {XW{1'b0}}, {YW{1'b0}}});
        frame_start = 1'b1;
        #1;
        check("clear_overrun", overrun, 1'b1);
        step();
        frame_start = 1'b0;
        done = 1'b0;
        for (int k = 0; k < 25000; k++) begin
            step();
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        check("clear_finish", done, 1'b1);
        check("clear_count", px_count, SCR_W * SCR_H);
        check("clear_queue", exp_q.size(), 0);
        saw_busy = 1'b0;
        repeat (4) begin
            step();
            if (busy) saw_busy = 1'b1;
        end
        check("clear_no_frame", saw_busy, 1'b0);
    endtask

    // One frame. mode 1 also fires frame_start during DRAW and during DONE.
    task automatic run_frame(input int exp_pixels, input string tag, input int mode);
        logic [N_OBJ-1:0]    sv_en, sv_big;
        logic [N_OBJ*XW-1:0] sv_x;
        logic [N_OBJ*YW-1:0] sv_y;
        logic [N_OBJ*CW-1:0] sv_col;
        bit done, od, saw_busy;
        px_count = 0;
        fd_count = 0;
        push_frame();
        sv_en = obj_en; sv_big = obj_big; sv_x = obj_x; sv_y = obj_y; sv_col = obj_col;
        frame_start = 1'b1;
        #1;
        check({tag, "_start_no_overrun"}, overrun, 1'b0);
        step();
        frame_start = 1'b0;
        check({tag, "_snap"}, {busy, pix_valid}, 2'b10);
        done = 1'b0;
        od = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            step();
            frame_start = 1'b0;
            if (k == 0) begin
                // Shadow is loaded; scrambled inputs must not leak in.
                obj_en = ~sv_en; obj_big = ~sv_big; obj_x = ~sv_x; obj_y = ~sv_y;
                obj_col = ~sv_col;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
            if (mode == 1) begin
                if (!od && pix_valid && pix_col != BGC) begin
                    frame_start = 1'b1;
                    #1;
                    check({tag, "_overrun_draw"}, overrun, 1'b1);
                    od = 1'b1;
                end else if (frame_done) begin
                    frame_start = 1'b1;
                    #1;
                    check({tag, "_overrun_done"}, overrun, 1'b1);
                end
            end
        end
        obj_en = sv_en; obj_big = sv_big; obj_x = sv_x; obj_y = sv_y; obj_col = sv_col;
        check({tag, "_finish"}, done, 1'b1);
        check({tag, "_count"}, px_count, exp_pixels);
        check({tag, "_frame_done"}, fd_count, 1);
        check({tag, "_queue"}, exp_q.size(), 0);
        saw_busy = 1'b0;
        repeat (5) begin
            step();
            if (busy) saw_busy = 1'b1;
        end
        check({tag, "_no_extra_frame"}, saw_busy, 1'b0);
    endtask

    initial begin
        bit hit;
        resetn = 1'b0; frame_start = 1'b0; pix_ready = 1'b1;
        obj_en = '0; obj_big = '0; obj_x = '0; obj_y = '0; obj_col = '0;
        for (int s = 0; s < N_OBJ; s++) begin
            m_x[s] = 0; m_y[s] = 0; m_big[s] = 1'b0; m_drawn[s] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        frame_start = 1'b1;
        #1;
        check("rst_valid", pix_valid, 1'b0);
        check("rst_outs", {pix_x, pix_y, pix_col, frame_done, overrun}, 0);
        check("rst_busy", busy, 1'b1);
        frame_start = 1'b0;

        clear_phase();

        set_slot(0, 1, 1, 10, 20, 1);
        run_frame(25, "f1_draw", 0);
        set_slot(0, 1, 1, 11, 20, 1);
        run_frame(50, "f2_move", 0);
        set_slot(0, 0, 0, 0, 0, 0);
        run_frame(25, "f3_erase_only", 0);
        set_slot(3, 1, 1, 158, 118, 5);
        run_frame(4, "f4_corner_clip", 0);

        rand_ready = 1'b1;
        set_slot(3, 1, 1, 50, 60, 6);
        set_slot(5, 1, 0, 100, 100, 2);
        set_slot(7, 1, 1, 3, 0, 7);
        run_frame(55, "f5_random_ready", 0);
        rand_ready = 1'b0;
        step();

        run_frame(102, "f6_overrun", 1);

        // Reset while a sprite is being drawn.
        push_frame();
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 500; k++) begin
            step();
            if (pix_valid && pix_col != BGC) begin
                hit = 1'b1;
                break;
            end
        end
        check("mid_draw_reached", hit, 1'b1);
        resetn = 1'b0;
        #1;
        check("mid_rst_valid", pix_valid, 1'b0);
        check("mid_rst_outs", {pix_x, pix_y, pix_col, frame_done, overrun}, 0);
        exp_q.delete();
        for (int s = 0; s < N_OBJ; s++) m_drawn[s] = 1'b0;
        step();
        step();
        clear_phase();

        // Footprint history was cleared by reset: draws only, no erases.
        run_frame(51, "f7_after_reset", 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
